// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
//   Shared types and constants for the staged reset sequencer.
//
//   seq_state_t : sequencer states
//                   ASSERT   - all domains held in reset; counting request-free hold
//                   DELAY    - spacing before the next domain is released
//                   WAIT_ACK - current domain released; waiting for its ack
//                   DONE     - every domain released and acked
//                   ERROR    - a domain failed to ack in time; all domains held
//   LED_*       : led_status encodings ({heartbeat/error, done})
//   led_done()  : led_status value in DONE for a given heartbeat phase
// -----------------------------------------------------------------------------
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ASSERT   = 3'd0,
    DELAY    = 3'd1,
    WAIT_ACK = 3'd2,
    DONE     = 3'd3,
    ERROR    = 3'd4
  } seq_state_t;

  localparam logic [1:0] LED_OFF = 2'b00;
  localparam logic [1:0] LED_ERR = 2'b10;

  // In DONE, bit 0 is the solid "done" indication and bit 1 carries the
  // heartbeat phase.
  function automatic logic [1:0] led_done(input logic hb_phase);
    return {hb_phase, 1'b1};
  endfunction

endpackage : reset_seq_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Per-bit two-flop synchronizer for slow, level-type signals that are
//   asynchronous to clk. Both flop stages load RESET_VAL while reset is high,
//   so the synchronized output is at a known level during and right after
//   reset.
//
//   Parameters:
//     WIDTH     - number of independent bits
//     RESET_VAL - value loaded into both stages while reset is high
//
//   Ports:
//     clk    in   1      destination clock
//     reset  in   1      asynchronous, active-high reset
//     d      in   WIDTH  asynchronous input bits
//     q      out  WIDTH  synchronized bits, two clk edges after d
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int   WIDTH     = 1,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // First stage may go metastable; only q is used downstream.
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= {WIDTH{RESET_VAL}};
      q    <= {WIDTH{RESET_VAL}};
    end else begin
      // NOTE: non-blocking so q takes the pre-edge value of meta; blocking
      // assignments here would collapse the two stages into one.
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//   Staged reset controller between the board reset logic and the qsys_top
//   reset inputs. Reset requests from several sources are synchronized and
//   merged; once the merged request has been absent for HOLD_MIN cycles the
//   downstream domains are released one at a time in index order, each only
//   after the previous one has acknowledged. A missing ack (ACK_TIMEOUT != 0)
//   drops every domain back into reset and flags a sticky error until the
//   next request restarts sequencing.
//
//   Parameters:
//     NUM_REQ     - number of active-high reset request inputs
//     NUM_STAGES  - number of sequenced reset domains
//     HOLD_MIN    - request-free cycles before sequencing starts (>= 1)
//     STAGE_DELAY - cycles from previous ack (or hold end) to next release (>= 1)
//     ACK_TIMEOUT - max cycles to wait for a stage ack; 0 waits forever
//     HB_DIV      - LED heartbeat half-period in cycles (>= 1)
//     CNT_WIDTH   - counter width; must hold every count parameter
//
//   Ports:
//     clk            in   1           system clock (100 MHz)
//     reset          in   1           asynchronous, active-high (ninit_done)
//     rst_req        in   NUM_REQ     reset requests, asynchronous to clk
//     stage_ack      in   NUM_STAGES  per-domain ready acks, synchronous to clk
//     stage_reset_n  out  NUM_STAGES  active-low domain resets
//     seq_done       out  1           all domains released and acked
//     seq_error      out  1           ack timeout seen; cleared by next request
//     led_status     out  2           [0]=done, [1]=heartbeat (DONE) / 1 (ERROR)
//
//   Every output is a flop; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_MIN    = 1000,
  parameter int STAGE_DELAY = 10000,
  parameter int ACK_TIMEOUT = 100000,
  parameter int HB_DIV      = 50000000,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    rst_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  seq_done,
  output logic                  seq_error,
  output logic [1:0]            led_status
);

  // ---------------------------------------------------------------------------
  // Local types and terminal counts
  // ---------------------------------------------------------------------------
  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  typedef logic [CNT_WIDTH-1:0] cnt_t;
  typedef logic [IDX_W-1:0]     idx_t;

  localparam cnt_t CNT_MAX     = '1;
  localparam cnt_t HOLD_LAST   = cnt_t'(HOLD_MIN - 1);
  localparam cnt_t DELAY_LAST  = cnt_t'(STAGE_DELAY - 1);
  localparam bit   ACK_TMO_EN  = (ACK_TIMEOUT != 0);
  localparam cnt_t ACK_LAST    = cnt_t'(ACK_TMO_EN ? ACK_TIMEOUT - 1 : 0);
  localparam cnt_t HB_LAST     = cnt_t'(HB_DIV - 1);
  localparam idx_t IDX_LAST    = idx_t'(NUM_STAGES - 1);

  // The shared phase counter sticks at its maximum instead of wrapping, so a
  // very long wait can never alias back onto a terminal count.
  function automatic cnt_t sat_inc(input cnt_t value);
    return (value == CNT_MAX) ? value : value + cnt_t'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Request synchronization and merge
  // ---------------------------------------------------------------------------
  // Synchronizer flops reset to 1: every source reads as requesting while
  // reset is high and for two edges after, so the hold count always starts
  // from a clean request-free point.
  logic [NUM_REQ-1:0] req_sync;
  logic               req_any;

  sync_2ff #(
    .WIDTH     (NUM_REQ),
    .RESET_VAL (1'b1)
  ) u_req_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rst_req),
    .q     (req_sync)
  );

  assign req_any = |req_sync;

  // ---------------------------------------------------------------------------
  // Sequencer state
  // ---------------------------------------------------------------------------
  seq_state_t state;
  cnt_t       cnt;     // hold / stage delay / ack wait, depending on state
  idx_t       idx;     // domain currently being released or acked
  cnt_t       hb_cnt;  // heartbeat divider, runs only in DONE
  logic       hb;      // heartbeat phase driven onto led_status[1]

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ASSERT;
      cnt           <= '0;
      idx           <= '0;
      stage_reset_n <= '0;
      seq_done      <= 1'b0;
      seq_error     <= 1'b0;
      led_status    <= LED_OFF;
      hb_cnt        <= '0;
      hb            <= 1'b0;
    end else begin
      // Heartbeat is held cleared everywhere except DONE, which overrides.
      hb_cnt <= '0;
      hb     <= 1'b0;

      if (req_any) begin
        // A live request wins over every other transition and restarts the
        // whole chain, including recovery from ERROR.
        state         <= ASSERT;
        cnt           <= '0;
        idx           <= '0;
        stage_reset_n <= '0;
        seq_done      <= 1'b0;
        seq_error     <= 1'b0;
        led_status    <= LED_OFF;
      end else begin
        case (state)
          ASSERT: begin
            if (cnt == HOLD_LAST) begin
              state <= DELAY;
              cnt   <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end

          DELAY: begin
            if (cnt == DELAY_LAST) begin
              // Earlier domains keep their release; only idx is added.
              stage_reset_n[idx] <= 1'b1;
              state              <= WAIT_ACK;
              cnt                <= '0;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end

          WAIT_ACK: begin
            // An ack already high on the first WAIT_ACK cycle is taken, and
            // an ack arriving on the timeout cycle still wins.
            if (stage_ack[idx]) begin
              if (idx == IDX_LAST) begin
                state         <= DONE;
                stage_reset_n <= '1;
                seq_done      <= 1'b1;
                led_status    <= led_done(1'b0);
              end else begin
                idx   <= idx + idx_t'(1);
                state <= DELAY;
                cnt   <= '0;
              end
            end else if (ACK_TMO_EN && (cnt == ACK_LAST)) begin
              state         <= ERROR;
              stage_reset_n <= '0;
              seq_error     <= 1'b1;
              led_status    <= LED_ERR;
            end else begin
              cnt <= sat_inc(cnt);
            end
          end

          DONE: begin
            // Stage acks are ignored here; only req_any leaves DONE.
            if (hb_cnt == HB_LAST) begin
              hb         <= ~hb;
              led_status <= led_done(~hb);
            end else begin
              hb_cnt     <= hb_cnt + cnt_t'(1);
              hb         <= hb;
              led_status <= led_done(hb);
            end
          end

          ERROR: begin
            // Outputs were set on entry; wait here for a new request.
          end

          // NOTE: the enum leaves three encodings unused; falling back to a
          // fully reset ASSERT keeps a corrupted state from holding any
          // domain half-released.
          default: begin
            state         <= ASSERT;
            cnt           <= '0;
            idx           <= '0;
            stage_reset_n <= '0;
            seq_done      <= 1'b0;
            seq_error     <= 1'b0;
            led_status    <= LED_OFF;
          end
        endcase
      end
    end
  end

endmodule : reset_sequencer

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//   Scenario bench for reset_sequencer. Each scenario pushes the output
//   changes it expects (cycle stamp + output values) into a scoreboard queue
//   as it drives stimulus; a negedge monitor pops and compares an entry every
//   time the DUT outputs change. Downstream domains are modelled as acking one
//   cycle after their reset is released.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int NUM_REQ     = 3;
  localparam int NUM_STAGES  = 3;
  localparam int HOLD_MIN    = 4;
  localparam int STAGE_DELAY = 8;
  localparam int ACK_TIMEOUT = 16;
  localparam int HB_DIV      = 4;

  // Timing of the environment as seen from the DUT boundary.
  localparam int SYNC_LAT = 2;                              // rst_req -> req_any
  localparam int ACK_LAT  = 2;                              // release -> ack taken
  localparam int REL0     = SYNC_LAT + HOLD_MIN + STAGE_DELAY;
  localparam int STEP     = ACK_LAT + STAGE_DELAY;          // release to release

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_REQ-1:0]    rst_req = '0;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] stage_reset_n;
  logic                  seq_done;
  logic                  seq_error;
  logic [1:0]            led_status;

  logic [NUM_STAGES-1:0] ack_mask = '1;
  logic [NUM_STAGES-1:0] ack_q = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int base     = 0;

  reset_sequencer #(
    .NUM_REQ     (NUM_REQ),
    .NUM_STAGES  (NUM_STAGES),
    .HOLD_MIN    (HOLD_MIN),
    .STAGE_DELAY (STAGE_DELAY),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .HB_DIV      (HB_DIV),
    .CNT_WIDTH   (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rst_req       (rst_req),
    .stage_ack     (stage_ack),
    .stage_reset_n (stage_reset_n),
    .seq_done      (seq_done),
    .seq_error     (seq_error),
    .led_status    (led_status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream domain model: ready one cycle after its reset is released.
  always @(posedge clk) ack_q <= stage_reset_n & ack_mask;
  assign stage_ack = ack_q;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int         cyc;
    logic [2:0] srn;
    logic       done;
    logic       err;
    logic [1:0] led;
  } ev_t;

  ev_t  exp_q[$];
  bit   mon_en = 1'b0;
  logic [6:0] prev_obs = '0;

  task automatic expect_ev(input int dc, input logic [2:0] s, input logic d,
                           input logic e, input logic [1:0] l);
    ev_t ev;
    ev.cyc  = base + dc;
    ev.srn  = s;
    ev.done = d;
    ev.err  = e;
    ev.led  = l;
    exp_q.push_back(ev);
  endtask

  always @(negedge clk) begin
    logic [6:0] cur;
    ev_t        ev;
    cur = {stage_reset_n, seq_done, seq_error, led_status};
    if (mon_en && (cur !== prev_obs)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: cyc=%0d got srn=%b done=%b err=%b led=%b, required no change",
                 cyc, stage_reset_n, seq_done, seq_error, led_status);
      end else begin
        ev = exp_q.pop_front();
        if ((ev.cyc !== cyc) || ({ev.srn, ev.done, ev.err, ev.led} !== cur)) begin
          n_fail++;
          $display("FAIL output_change: got cyc=%0d srn=%b done=%b err=%b led=%b, required cyc=%0d srn=%b done=%b err=%b led=%b",
                   cyc, stage_reset_n, seq_done, seq_error, led_status,
                   ev.cyc, ev.srn, ev.done, ev.err, ev.led);
        end
      end
    end
    prev_obs = cur;
  end

  // Advance to the negedge at base+dc (bounded by the cycle target), then
  // step past the monitor's sample at that edge.
  task automatic wait_until(input int dc);
    while (cyc < base + dc) @(negedge clk);
    #1;
  endtask

  // Drive a request long enough to park the DUT in ASSERT with outputs low.
  task automatic force_assert();
    @(negedge clk);
    rst_req = 3'b001;
    repeat (5) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (stage_reset_n !== 3'b000) begin
      n_fail++; $display("FAIL reset_srn: got %b, required 000", stage_reset_n);
    end
    n_checks++;
    if (seq_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b, required 0", seq_done);
    end
    n_checks++;
    if (seq_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_error: got %b, required 0", seq_error);
    end
    n_checks++;
    if (led_status !== 2'b00) begin
      n_fail++; $display("FAIL reset_led: got %b, required 00", led_status);
    end
  endtask

  task automatic test_normal_sequence();
    int d;
    @(negedge clk);
    base = cyc;
    d = REL0 + 2 * STEP + ACK_LAT;
    expect_ev(REL0,              3'b001, 1'b0, 1'b0, 2'b00);
    expect_ev(REL0 + STEP,       3'b011, 1'b0, 1'b0, 2'b00);
    expect_ev(REL0 + 2 * STEP,   3'b111, 1'b0, 1'b0, 2'b00);
    expect_ev(d,                 3'b111, 1'b1, 1'b0, 2'b01);
    expect_ev(d + HB_DIV,        3'b111, 1'b1, 1'b0, 2'b11);
    expect_ev(d + 2 * HB_DIV,    3'b111, 1'b1, 1'b0, 2'b01);
    expect_ev(d + 3 * HB_DIV,    3'b111, 1'b1, 1'b0, 2'b11);
    mon_en = 1'b1;
    reset  = 1'b0;
    wait_until(d + 3 * HB_DIV + 2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL normal_missing: %0d changes not seen, next required cyc=%0d srn=%b",
               exp_q.size(), exp_q[0].cyc, exp_q[0].srn);
      exp_q.delete();
    end
    mon_en = 1'b0;
  endtask

  task automatic test_min_hold_restart();
    int rel0;
    force_assert();
    base   = cyc;
    rst_req = '0;
    // Glitch returns req_any exactly when the hold count has reached 2.
    rel0 = 2 + 1 + SYNC_LAT + HOLD_MIN + STAGE_DELAY;
    expect_ev(rel0,                     3'b001, 1'b0, 1'b0, 2'b00);
    expect_ev(rel0 + STEP,              3'b011, 1'b0, 1'b0, 2'b00);
    expect_ev(rel0 + 2 * STEP,          3'b111, 1'b0, 1'b0, 2'b00);
    expect_ev(rel0 + 2 * STEP + ACK_LAT, 3'b111, 1'b1, 1'b0, 2'b01);
    mon_en = 1'b1;
    wait_until(2);
    rst_req = 3'b010;
    wait_until(3);
    rst_req = '0;
    wait_until(rel0 + 2 * STEP + ACK_LAT + 2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL min_hold_missing: %0d changes not seen, next required cyc=%0d srn=%b",
               exp_q.size(), exp_q[0].cyc, exp_q[0].srn);
      exp_q.delete();
    end
    mon_en = 1'b0;
  endtask

  task automatic test_ack_timeout();
    ack_mask = 3'b101;
    force_assert();
    base    = cyc;
    rst_req = '0;
    expect_ev(REL0,                      3'b001, 1'b0, 1'b0, 2'b00);
    expect_ev(REL0 + STEP,               3'b011, 1'b0, 1'b0, 2'b00);
    expect_ev(REL0 + STEP + ACK_TIMEOUT, 3'b000, 1'b0, 1'b1, 2'b10);
    mon_en = 1'b1;
    // Long idle window: ERROR must hold with no further output change.
    wait_until(REL0 + STEP + ACK_TIMEOUT + 60);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_missing: %0d changes not seen, next required cyc=%0d srn=%b",
               exp_q.size(), exp_q[0].cyc, exp_q[0].srn);
      exp_q.delete();
    end
    n_checks++;
    if (stage_reset_n !== 3'b000) begin
      n_fail++; $display("FAIL error_hold_srn: got %b, required 000", stage_reset_n);
    end
    n_checks++;
    if (seq_error !== 1'b1) begin
      n_fail++; $display("FAIL error_hold_flag: got %b, required 1", seq_error);
    end
    n_checks++;
    if (led_status !== 2'b10) begin
      n_fail++; $display("FAIL error_hold_led: got %b, required 10", led_status);
    end
    n_checks++;
    if (seq_done !== 1'b0) begin
      n_fail++; $display("FAIL error_hold_done: got %b, required 0", seq_done);
    end
    mon_en = 1'b0;
  endtask

  task automatic test_error_recovery();
    int clr;
    int rel0;
    @(negedge clk);
    base = cyc;
    clr  = 1 + SYNC_LAT;             // one-cycle pulse seen by the FSM
    rel0 = clr + HOLD_MIN + STAGE_DELAY;
    expect_ev(clr,                       3'b000, 1'b0, 1'b0, 2'b00);
    expect_ev(rel0,                      3'b001, 1'b0, 1'b0, 2'b00);
    expect_ev(rel0 + STEP,               3'b011, 1'b0, 1'b0, 2'b00);
    expect_ev(rel0 + 2 * STEP,           3'b111, 1'b0, 1'b0, 2'b00);
    expect_ev(rel0 + 2 * STEP + ACK_LAT, 3'b111, 1'b1, 1'b0, 2'b01);
    mon_en   = 1'b1;
    rst_req  = 3'b001;
    ack_mask = 3'b111;
    wait_until(1);
    rst_req = '0;
    wait_until(clr + 1);
    n_checks++;
    if (seq_error !== 1'b0) begin
      n_fail++; $display("FAIL recovery_error_clear: got %b, required 0", seq_error);
    end
    wait_until(rel0 + 2 * STEP + ACK_LAT + 2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL recovery_missing: %0d changes not seen, next required cyc=%0d srn=%b",
               exp_q.size(), exp_q[0].cyc, exp_q[0].srn);
      exp_q.delete();
    end
    mon_en = 1'b0;
  endtask

  task automatic test_mid_sequence_request();
    int req_at;
    int rel0b;
    force_assert();
    base    = cyc;
    rst_req = '0;
    req_at  = REL0 + STEP + 4;       // stage 1 released, stage 2 still held
    rel0b   = req_at + 2 + SYNC_LAT + HOLD_MIN + STAGE_DELAY;
    expect_ev(REL0,                       3'b001, 1'b0, 1'b0, 2'b00);
    expect_ev(REL0 + STEP,                3'b011, 1'b0, 1'b0, 2'b00);
    expect_ev(req_at + SYNC_LAT + 1,      3'b000, 1'b0, 1'b0, 2'b00);
    expect_ev(rel0b,                      3'b001, 1'b0, 1'b0, 2'b00);
    expect_ev(rel0b + STEP,               3'b011, 1'b0, 1'b0, 2'b00);
    expect_ev(rel0b + 2 * STEP,           3'b111, 1'b0, 1'b0, 2'b00);
    expect_ev(rel0b + 2 * STEP + ACK_LAT, 3'b111, 1'b1, 1'b0, 2'b01);
    mon_en = 1'b1;
    wait_until(req_at);
    n_checks++;
    if (stage_reset_n !== 3'b011) begin
      n_fail++; $display("FAIL mid_pre_srn: got %b, required 011", stage_reset_n);
    end
    rst_req = 3'b100;
    wait_until(req_at + 2);
    rst_req = '0;
    wait_until(rel0b - 4);
    n_checks++;
    if (stage_reset_n !== 3'b000) begin
      n_fail++; $display("FAIL mid_held_srn: got %b, required 000", stage_reset_n);
    end
    n_checks++;
    if (seq_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_done_low: got %b, required 0", seq_done);
    end
    wait_until(rel0b + 2 * STEP + ACK_LAT + 2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_missing: %0d changes not seen, next required cyc=%0d srn=%b",
               exp_q.size(), exp_q[0].cyc, exp_q[0].srn);
      exp_q.delete();
    end
    mon_en = 1'b0;
  endtask

  task automatic test_async_reset_done();
    int d;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    base = cyc;
    expect_ev(0, 3'b000, 1'b0, 1'b0, 2'b00);
    mon_en = 1'b1;
    reset  = 1'b1;
    #1;
    n_checks++;
    if (stage_reset_n !== 3'b000) begin
      n_fail++; $display("FAIL async_srn: got %b, required 000", stage_reset_n);
    end
    n_checks++;
    if (seq_done !== 1'b0) begin
      n_fail++; $display("FAIL async_done: got %b, required 0", seq_done);
    end
    n_checks++;
    if (seq_error !== 1'b0) begin
      n_fail++; $display("FAIL async_error: got %b, required 0", seq_error);
    end
    n_checks++;
    if (led_status !== 2'b00) begin
      n_fail++; $display("FAIL async_led: got %b, required 00", led_status);
    end
    repeat (3) @(negedge clk);
    base = cyc;
    d    = REL0 + 2 * STEP + ACK_LAT;
    expect_ev(REL0,            3'b001, 1'b0, 1'b0, 2'b00);
    expect_ev(REL0 + STEP,     3'b011, 1'b0, 1'b0, 2'b00);
    expect_ev(REL0 + 2 * STEP, 3'b111, 1'b0, 1'b0, 2'b00);
    expect_ev(d,               3'b111, 1'b1, 1'b0, 2'b01);
    reset = 1'b0;
    wait_until(d + 2);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL async_missing: %0d changes not seen, next required cyc=%0d srn=%b",
               exp_q.size(), exp_q[0].cyc, exp_q[0].srn);
      exp_q.delete();
    end
    mon_en = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and watchdog
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_normal_sequence();
    test_min_hold_restart();
    test_ack_timeout();
    test_error_recovery();
    test_mid_sequence_request();
    test_async_reset_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_reset_sequencer
